// File: rtl/toggle_port_responder_if.sv
// Toggle-handshake memory port bundle: initiator-side port_* signals plus the
// backing-store mem_* bus. The responder uses the slave view.
`default_nettype none

interface toggle_port_responder_if #(
  parameter int AW = 19,
  parameter int DW = 16
);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;

  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d, mem_rdata, mem_busy,
    output port_ack, port_q, mem_addr, mem_be, mem_wdata, mem_we, mem_rd
  );

  modport master (
    output port_req, port_a, port_ds, port_we, port_d, mem_rdata, mem_busy,
    input  port_ack, port_q, mem_addr, mem_be, mem_wdata, mem_we, mem_rd
  );
endinterface

`default_nettype wire

// File: rtl/toggle_port_responder.sv
// Responder end of the toggle-request memory port: one memory access per req flip.
// Optional macro TOGGLE_SYNC_EN adds a 2-flop synchronizer on port_req.
`default_nettype none

module toggle_port_responder #(
  parameter int AW     = 19,
  parameter int DW     = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  toggle_port_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] C_RD_LAT = 4'(RD_LAT);
  localparam logic [3:0] C_WR_LAT = 4'(WR_LAT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] q_q;
  logic          req_seen;
  logic          pending;
  logic          latch_en;
  logic          done;
  logic          mem_we_o;
  logic          mem_rd_o;

`ifdef TOGGLE_SYNC_EN
  logic req_meta_q;
  logic req_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= bus.port_req;
      req_sync_q <= req_meta_q;
    end
  end

  assign req_seen = req_sync_q;
`else
  assign req_seen = bus.port_req;
`endif

  assign pending = req_seen ^ ack_q;

  // State register plus the datapath registers the FSM steers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        addr_q  <= bus.port_a;
        be_q    <= bus.port_ds;
        wdata_q <= bus.port_d;
        we_q    <= bus.port_we;
      end
      if (done) begin
        ack_q <= ~ack_q;
        if (!we_q) begin
          q_q <= bus.mem_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending && !bus.mem_busy) begin
          latch_en = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = we_q ? C_WR_LAT : C_RD_LAT;
        state_d = (cnt_d == 4'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // The final count value still costs one cycle here before DONE.
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_we_o = 1'b0;
    mem_rd_o = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_ISSUE: begin
        mem_we_o = we_q;
        mem_rd_o = ~we_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign bus.port_ack  = ack_q;
  assign bus.port_q    = q_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_o;
  assign bus.mem_rd    = mem_rd_o;

endmodule

`default_nettype wire

// File: tb/tb_toggle_port_responder.sv
// Bench for toggle_port_responder: event-time reference model plus directed and random traffic.
`default_nettype none

module tb_toggle_port_responder;

  localparam int AW     = 19;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int MEMW   = 1024;
`ifdef TOGGLE_SYNC_EN
  localparam int C_SYNC = 2;
`else
  localparam int C_SYNC = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  toggle_port_responder_if #(.AW(AW), .DW(DW)) bus ();

  toggle_port_responder #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    logic [31:0] p;
    p = i * 40503;
    return (i == 16) ? 16'h1234 : (p[15:0] ^ 16'h5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Backing store: byte-lane writes, reads return data RD_LAT cycles after the strobe.
  logic [15:0] bs [MEMW];
  bit          bs_init = 0;
  logic [15:0] pend_val;
  int          pend_cnt = 0;
  int          n_we = 0;
  int          n_rd = 0;

  always @(posedge clk) begin
    if (!bs_init) begin
      for (int i = 0; i < MEMW; i++) bs[i] = init_val(i);
      bs_init = 1;
      bus.mem_rdata <= 16'hDEAD;
    end else begin
      if (bus.mem_we) begin
        n_we++;
        if (bus.mem_be[0]) bs[int'(bus.mem_addr[9:0])][7:0]  = bus.mem_wdata[7:0];
        if (bus.mem_be[1]) bs[int'(bus.mem_addr[9:0])][15:8] = bus.mem_wdata[15:8];
      end
      if (bus.mem_rd) begin
        n_rd++;
        pend_val = bs[int'(bus.mem_addr[9:0])];
        pend_cnt = RD_LAT;
        bus.mem_rdata <= 16'hDEAD;
      end else if (pend_cnt == 1) begin
        bus.mem_rdata <= pend_val;
        pend_cnt = 0;
      end else if (pend_cnt > 1) begin
        pend_cnt--;
      end
    end
  end

  // Reference model: an accepted request strobes the next cycle and acks LAT+2 edges later.
  logic [15:0]   mm [MEMW];
  bit            mm_init = 0;
  logic          m_ack, m_active, m_wel, e_we, e_rd, sh1, sh2, req_seen;
  logic [15:0]   m_q, m_wd, m_rv;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_be;
  int            cyc = 0;
  int            t_ack = 0;
  int            idx;

  always @(posedge clk) begin
    if (!mm_init) begin
      for (int i = 0; i < MEMW; i++) mm[i] = init_val(i);
      mm_init = 1;
    end
    cyc++;
    if (!reset_n) begin
      m_ack = 0; m_active = 0; m_wel = 0; e_we = 0; e_rd = 0; sh1 = 0; sh2 = 0;
      m_q = 0; m_wd = 0; m_addr = 0; m_be = 0;
    end else begin
      if (C_SYNC != 0) begin
        req_seen = sh2; sh2 = sh1; sh1 = bus.port_req;
      end else begin
        req_seen = bus.port_req;
      end
      e_we = 0; e_rd = 0;
      if (!m_active) begin
        if ((req_seen ^ m_ack) && !bus.mem_busy) begin
          m_active = 1;
          m_addr = bus.port_a; m_be = bus.port_ds; m_wd = bus.port_d; m_wel = bus.port_we;
          t_ack = cyc + (m_wel ? WR_LAT : RD_LAT) + 2;
          e_we = m_wel; e_rd = !m_wel;
          idx = int'(m_addr[9:0]);
          if (m_wel) begin
            if (m_be[0]) mm[idx][7:0]  = m_wd[7:0];
            if (m_be[1]) mm[idx][15:8] = m_wd[15:8];
          end else begin
            m_rv = mm[idx];
          end
        end
      end else if (cyc == t_ack) begin
        m_ack = ~m_ack;
        if (!m_wel) m_q = m_rv;
        m_active = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mm_init) begin
      chk("port_ack",  32'(bus.port_ack),  32'(m_ack));
      chk("port_q",    32'(bus.port_q),    32'(m_q));
      chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
      chk("mem_be",    32'(bus.mem_be),    32'(m_be));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
      chk("mem_we",    32'(bus.mem_we),    32'(e_we));
      chk("mem_rd",    32'(bus.mem_rd),    32'(e_rd));
    end
  end

  task automatic wait_ack(input int budget, input bit rnd);
    bit seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rnd) begin
        bus.mem_busy = ($urandom_range(0, 3) == 0);
        if (C_SYNC == 0) begin
          bus.port_a  = AW'($urandom_range(0, MEMW - 1));
          bus.port_d  = 16'($urandom);
          bus.port_ds = 2'($urandom);
          bus.port_we = 1'($urandom);
        end
      end
      if (bus.port_ack == bus.port_req) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("ack_timeout", 32'(bus.port_ack), 32'(bus.port_req));
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [1:0] ds,
                        input logic [15:0] d, input bit rnd);
    @(negedge clk);
    bus.port_we = we; bus.port_a = a; bus.port_ds = ds; bus.port_d = d;
    bus.port_req = ~bus.port_req;
    wait_ack(64, rnd);
  endtask

  int          errs;
  int          w0, r0;
  logic [15:0] iv;

  initial begin
    bus.port_req = 0; bus.port_a = '0; bus.port_ds = 2'b00; bus.port_we = 0;
    bus.port_d = '0; bus.mem_busy = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("reset_ack", 32'(bus.port_ack), 32'h0);
    chk("reset_q",   32'(bus.port_q),   32'h0);

    // Reset then read of 0x00010.
    @(negedge clk);
    bus.port_we = 0; bus.port_a = AW'(16); bus.port_ds = 2'b11; bus.port_req = 1;
    repeat (C_SYNC + 1) @(posedge clk);
    #1 chk("rd_strobe", 32'(bus.mem_rd), 32'h1);
    chk("rd_addr", 32'(bus.mem_addr), 32'h10);
    repeat (3) @(posedge clk);
    #1 chk("rd_ack_early", 32'(bus.port_ack), 32'h0);
    @(posedge clk);
    #1 chk("rd_ack", 32'(bus.port_ack), 32'h1);
    chk("rd_q", 32'(bus.port_q), 32'h1234);

    // Upper-byte write to 0x00003.
    @(negedge clk);
    bus.port_we = 1; bus.port_a = AW'(3); bus.port_ds = 2'b10; bus.port_d = 16'hAB00;
    bus.port_req = 0;
    repeat (C_SYNC + 1) @(posedge clk);
    #1 chk("wr_strobe", 32'(bus.mem_we), 32'h1);
    chk("wr_be",    32'(bus.mem_be),    32'h2);
    chk("wr_wdata", 32'(bus.mem_wdata), 32'hAB00);
    chk("wr_addr",  32'(bus.mem_addr),  32'h3);
    repeat (2) @(posedge clk);
    #1 chk("wr_ack_early", 32'(bus.port_ack), 32'h1);
    @(posedge clk);
    #1 chk("wr_ack", 32'(bus.port_ack), 32'h0);
    chk("wr_q_kept", 32'(bus.port_q), 32'h1234);
    iv = init_val(3);
    chk("wr_image", 32'(bs[3]), {16'h0, 8'hAB, iv[7:0]});

    // Reset while the read is waiting on memory latency.
    @(negedge clk);
    bus.port_we = 0; bus.port_a = AW'(16); bus.port_req = 1;
    repeat (C_SYNC + 2) @(posedge clk);
    #2 reset_n = 0;
    #1 chk("rst_rd", 32'(bus.mem_rd), 32'h0);
    chk("rst_we",  32'(bus.mem_we),  32'h0);
    chk("rst_ack", 32'(bus.port_ack), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    wait_ack(40, 0);
    chk("rst_reread_ack", 32'(bus.port_ack), 32'h1);
    chk("rst_reread_q",   32'(bus.port_q),   32'h1234);

    // Busy stall: request pending for 5 busy cycles.
    @(negedge clk);
    bus.mem_busy = 1;
    bus.port_we = 1; bus.port_a = AW'(5); bus.port_ds = 2'b11; bus.port_d = 16'h55AA;
    bus.port_req = 0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("busy_no_strobe", 32'(bus.mem_we | bus.mem_rd), 32'h0);
    end
    @(negedge clk);
    bus.mem_busy = 0;
    @(posedge clk);
    #1 chk("busy_issue", 32'(bus.mem_we), 32'h1);
    repeat (2) @(posedge clk);
    #1 chk("busy_ack_early", 32'(bus.port_ack), 32'h1);
    @(posedge clk);
    #1 chk("busy_ack", 32'(bus.port_ack), 32'h0);

    // Download burst: 256 word writes, data = address.
    w0 = n_we; r0 = n_rd;
    for (int i = 0; i < 256; i++) access(1'b1, AW'(i), 2'b11, 16'(i), 1'b0);
    chk("burst_we_count", 32'(n_we - w0), 32'd256);
    chk("burst_rd_count", 32'(n_rd - r0), 32'd0);
    errs = 0;
    for (int i = 0; i < 256; i++) if (bs[i] !== 16'(i)) errs++;
    chk("burst_image", 32'(errs), 32'd0);

    // Random mixed traffic with random busy.
    for (int i = 0; i < 200; i++)
      access(1'($urandom), AW'($urandom_range(0, MEMW - 1)), 2'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    bus.mem_busy = 0;
    repeat (5) @(negedge clk);
    errs = 0;
    for (int i = 0; i < MEMW; i++) if (bs[i] !== mm[i]) errs++;
    chk("final_image", 32'(errs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
Responder (target) end of the codebase's toggle-request memory port handshake. An initiator flips port_req once per access. The ROM download controller flips it once per ioctl byte. This block detects each flip and performs one read or byte-lane write on a simple synchronous memory. It then flips port_ack when the access is complete. It fronts BRAM/SDRAM-style backing stores for download writes and CPU/graphics reads.

Parameters:
AW, 19, port word-address width
DW, 16, data width; must be 16 so that port_ds maps to two byte lanes
RD_LAT, 2, cycles from mem_rd strobe to valid mem_rdata (1..15)
WR_LAT, 1, cycles from mem_we strobe to write-complete (0..15)

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
port_req  in  1  request toggle; a request is pending while port_req != port_ack
port_ack  out  1  acknowledge toggle
port_a  in  AW  word address
port_ds  in  2  byte enables {hi,lo}
port_we  in  1  1 = write, 0 = read
port_d  in  DW  write data
port_q  out  DW  read data; valid from the cycle port_ack flips until the next read completes
mem_addr  out  AW  backing-store address
mem_be  out  2  backing-store byte enables
mem_wdata  out  DW  backing-store write data
mem_we  out  1  one-cycle write strobe
mem_rd  out  1  one-cycle read strobe
mem_rdata  in  DW  read data, valid RD_LAT cycles after mem_rd
mem_busy  in  1  backing store cannot accept a new access (refresh, other port)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs are forced to 0 and held there while reset is asserted.
  - Affected outputs: port_ack, port_q, mem_addr, mem_be, mem_wdata, mem_we, mem_rd.
  - The FSM returns to IDLE and the latency counter clears.
  - An in-flight access is abandoned: no ack flip, and memory strobes drop immediately.
  - After release, a pending toggle (port_req=1 while ack=0) is serviced normally.
- pending = port_req XOR port_ack, both registered values.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If pending and !mem_busy: latch port_a, port_ds, port_we and port_d into mem_addr/mem_be/mem_wdata and an internal we flag; go to ISSUE.
  - If pending and mem_busy: stay in IDLE with no latch; retry every cycle.
- ISSUE (exactly 1 cycle):
  - Assert mem_we if the latched we flag is set, otherwise mem_rd.
  - Load the counter with RD_LAT or WR_LAT; go to WAIT. If the loaded value is 0, skip straight to DONE.
  - mem_busy is ignored once in ISSUE.
- WAIT: decrement the counter each cycle; on reaching 1 go to DONE.
- DONE (1 cycle):
  - On a read, register mem_rdata into port_q. On a write, port_q is unchanged.
  - Flip port_ack and go to IDLE.
- Latency: sampling edge (IDLE, pending, !busy) to port_ack flip = LAT+2 cycles. That is 4 for a read and 3 for a write at default parameters.
- mem_addr, mem_be and mem_wdata hold their values from latch until the next latch.
- port_ds=00 write: mem_we is still pulsed with mem_be=00, and the ack is returned. port_ds is ignored for reads; the full word is returned.
- Back-to-back: a new toggle arriving in the same cycle as the ack flip is seen as pending in the following IDLE cycle. The minimum request spacing is LAT+3 cycles.
- Protocol violation: if the initiator toggles twice before ack, pending is re-evaluated only in IDLE. A double toggle can therefore cancel or merge requests. The initiator must not toggle again until ack matches req.
- Inputs port_a, port_ds, port_we and port_d are sampled only at the IDLE latch edge. Later changes do not affect the access.

Optional Feature:
TOGGLE_SYNC_EN
- Defined: port_req passes through a 2-flop synchronizer before the pending compare. This allows the initiator to sit in another clock domain, e.g. clk_sys feeding a responder on clk_mem.
  - Latency from the raw port_req flip grows by 2 cycles.
  - The initiator must hold port_a, port_ds, port_we and port_d stable from its toggle until it sees the ack flip.
- Undefined: port_req is compared directly; single clock domain only.

Test Plan:
- Reset then read: reset_n low 3 cycles then high; mem models 0x1234 at address 0x00010; toggle req 0→1 with we=0 and a=0x00010.
  - Required: mem_rd pulses 1 cycle after sampling.
  - Required: port_ack goes 1 four cycles after sampling, with port_q=0x1234.
- Byte write: req toggle with we=1, a=0x00003, ds=10, d=0xAB00.
  - Required: one mem_we pulse with mem_be=10, mem_wdata=0xAB00, mem_addr=0x00003.
  - Required: ack flips 3 cycles after sampling; port_q unchanged.
- Busy stall: mem_busy held high 5 cycles while req is pending.
  - Required: no mem strobes while busy.
  - Required: the access issues the cycle after busy drops; ack flips at the normal latency counted from the first non-busy sample.
- Download burst: 256 writes, each toggling req the cycle after the ack flip, addresses 0..255, data = address.
  - Required: the memory image matches.
  - Required: exactly 256 mem_we pulses and 0 mem_rd pulses.
- Reset mid-read: assert reset_n low in WAIT.
  - Required: mem strobes drop immediately and port_ack=0.
  - Required: with port_req=1 after release, a fresh read completes and ack=1.
- TOGGLE_SYNC_EN build: repeat the reset-then-read scenario; ack must flip 6 cycles after the raw req flip with port_q=0x1234.
